// File: rtl/gated_pulse_counter.sv
// Gated two-stage pulse counter: counts synchronised rising edges of pulse_i inside a
// measurement gate (stop_i or cycle timeout), then latches the result with a valid/ack handshake.
module gated_pulse_counter #(
  parameter int LO_W        = 10,
  parameter int MODULUS     = 1000,
  parameter int HI_W        = 8,
  parameter int GATE_W      = 20,
  parameter int GATE_CYCLES = 0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pulse_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            wrap_o,
  output logic            valid_o,
  output logic            overflow_o,
  output logic [LO_W-1:0] count_lo_o,
  output logic [HI_W-1:0] count_hi_o
);

  // state | meaning
  // IDLE  | no gate open, no result pending
  // COUNT | gate open, edges accumulate, timer runs
  // HOLD  | result latched on ports, waiting for ack_i
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [LO_W-1:0]   LO_MAX    = LO_W'(MODULUS - 1);
  localparam logic [HI_W-1:0]   HI_MAX    = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam bit                GATE_EN   = (GATE_CYCLES != 0);

  state_t            state_q;
  logic              sync1_q, sync2_q, sync3_q;
  logic              edge_det;
  logic [LO_W-1:0]   lo_q, lo_d;
  logic [HI_W-1:0]   hi_q, hi_d;
  logic              ovf_q, ovf_d;
  logic              wrap_d;
  logic [GATE_W-1:0] timer_q;
  logic              timeout;
  logic              close_gate;
  logic              open_gate;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q & ~sync3_q;

  // Next running count if an edge lands now; also feeds the result latch on gate close.
  always_comb begin
    lo_d   = lo_q;
    hi_d   = hi_q;
    ovf_d  = ovf_q;
    wrap_d = 1'b0;
    if (edge_det) begin
      if (lo_q != LO_MAX) begin
        lo_d = lo_q + LO_W'(1);
      end else if (hi_q != HI_MAX) begin
        lo_d   = '0;
        hi_d   = hi_q + HI_W'(1);
        wrap_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign timeout    = GATE_EN && (timer_q == GATE_LAST);
  assign close_gate = stop_i || timeout;
  assign open_gate  = start_i && !stop_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      timer_q    <= '0;
      busy_o     <= 1'b0;
      wrap_o     <= 1'b0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      count_lo_o <= '0;
      count_hi_o <= '0;
    end else begin
      wrap_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (open_gate) begin
            state_q <= COUNT;
            busy_o  <= 1'b1;
            lo_q    <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            timer_q <= '0;
          end
        end
        COUNT: begin
          lo_q    <= lo_d;
          hi_q    <= hi_d;
          ovf_q   <= ovf_d;
          timer_q <= timer_q + GATE_W'(1);
          if (close_gate) begin
            // A wrap on the closing edge is still counted but not flagged: wrap_o is COUNT-only.
            state_q    <= HOLD;
            busy_o     <= 1'b0;
            valid_o    <= 1'b1;
            count_lo_o <= lo_d;
            count_hi_o <= hi_d;
            overflow_o <= ovf_d;
          end else begin
            wrap_o <= wrap_d;
          end
        end
        HOLD: begin
          if (ack_i) begin
            valid_o <= 1'b0;
            if (open_gate) begin
              state_q <= COUNT;
              busy_o  <= 1'b1;
              lo_q    <= '0;
              hi_q    <= '0;
              ovf_q   <= 1'b0;
              timer_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_pulse_counter.sv
// Bench for gated_pulse_counter: three shared-stimulus instances (wide high stage, narrow
// high stage for overflow, auto-timed gate) checked against constant tables and an arithmetic model.
module tb_gated_pulse_counter;

  localparam int M      = 10;
  localparam int HIW_A  = 4;
  localparam int HIW_B  = 2;
  localparam int GATE_C = 100;

  logic clk_i = 1'b0;
  logic rst_n_i, pulse_i, start_i, stop_i, ack_i;

  logic       busy_a, wrap_a, valid_a, ovf_a;
  logic [3:0] lo_a;
  logic [3:0] hi_a;
  logic       busy_b, wrap_b, valid_b, ovf_b;
  logic [3:0] lo_b;
  logic [1:0] hi_b;
  logic       busy_c, wrap_c, valid_c, ovf_c;
  logic [3:0] lo_c;
  logic [3:0] hi_c;

  int checks = 0;
  int errors = 0;
  int wrap_cnt_a = 0, wrap_cnt_b = 0, busy_cnt_c = 0;

  always #5 clk_i = ~clk_i;

  gated_pulse_counter #(.LO_W(4), .MODULUS(M), .HI_W(HIW_A), .GATE_W(8), .GATE_CYCLES(0)) u_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pulse_i(pulse_i), .start_i(start_i), .stop_i(stop_i),
    .ack_i(ack_i), .busy_o(busy_a), .wrap_o(wrap_a), .valid_o(valid_a), .overflow_o(ovf_a),
    .count_lo_o(lo_a), .count_hi_o(hi_a));

  gated_pulse_counter #(.LO_W(4), .MODULUS(M), .HI_W(HIW_B), .GATE_W(8), .GATE_CYCLES(0)) u_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pulse_i(pulse_i), .start_i(start_i), .stop_i(stop_i),
    .ack_i(ack_i), .busy_o(busy_b), .wrap_o(wrap_b), .valid_o(valid_b), .overflow_o(ovf_b),
    .count_lo_o(lo_b), .count_hi_o(hi_b));

  gated_pulse_counter #(.LO_W(4), .MODULUS(M), .HI_W(HIW_A), .GATE_W(8), .GATE_CYCLES(GATE_C)) u_c (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pulse_i(pulse_i), .start_i(start_i), .stop_i(stop_i),
    .ack_i(ack_i), .busy_o(busy_c), .wrap_o(wrap_c), .valid_o(valid_c), .overflow_o(ovf_c),
    .count_lo_o(lo_c), .count_hi_o(hi_c));

  always @(negedge clk_i) begin
    wrap_cnt_a += int'(wrap_a);
    wrap_cnt_b += int'(wrap_b);
    busy_cnt_c += int'(busy_c);
  end

  typedef struct {
    int n;
    int lo_a, hi_a, ovf_a, wr_a;
    int lo_b, hi_b, ovf_b, wr_b;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input bit s, input bit p, input bit a);
    start_i = s; stop_i = p; ack_i = a;
    tick();
    start_i = 1'b0; stop_i = 1'b0; ack_i = 1'b0;
  endtask

  task automatic pulses(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int h, l;
      h = rnd ? int'($urandom_range(2, 4)) : 2;
      l = rnd ? int'($urandom_range(2, 4)) : 2;
      pulse_i = 1'b1;
      repeat (h) tick();
      pulse_i = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One gate of n edges on both counting instances, then check the latched result and wraps.
  task automatic gate_and_check(input string tag, input int n, input bit rnd,
                                input int elo_a, input int ehi_a, input int eovf_a, input int ewr_a,
                                input int elo_b, input int ehi_b, input int eovf_b, input int ewr_b);
    int wa0, wb0;
    wa0 = wrap_cnt_a;
    wb0 = wrap_cnt_b;
    pulses(n, rnd);
    repeat (2) tick();
    strobe(1'b0, 1'b1, 1'b0);
    chk({tag, "_valid_a"}, int'(valid_a), 1);
    chk({tag, "_lo_a"}, int'(lo_a), elo_a);
    chk({tag, "_hi_a"}, int'(hi_a), ehi_a);
    chk({tag, "_ovf_a"}, int'(ovf_a), eovf_a);
    chk({tag, "_wrap_a"}, wrap_cnt_a - wa0, ewr_a);
    chk({tag, "_lo_b"}, int'(lo_b), elo_b);
    chk({tag, "_hi_b"}, int'(hi_b), ehi_b);
    chk({tag, "_ovf_b"}, int'(ovf_b), eovf_b);
    chk({tag, "_wrap_b"}, wrap_cnt_b - wb0, ewr_b);
  endtask

  // Reference result: total edges folded into digits, saturating at MODULUS*2^HI_W - 1.
  function automatic void model(input int n, input int hiw,
                                output int lo, output int hi, output int ovf, output int wr);
    int cap;
    cap = M * (1 << hiw);
    ovf = (n >= cap) ? 1 : 0;
    if (ovf == 1) begin
      lo = M - 1;
      hi = (1 << hiw) - 1;
      wr = hi;
    end else begin
      lo = n % M;
      hi = n / M;
      wr = hi;
    end
  endfunction

  initial begin
    vecs[0] = '{0,  0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{9,  9, 0, 0, 0,  9, 0, 0, 0};
    vecs[2] = '{10, 0, 1, 0, 1,  0, 1, 0, 1};
    vecs[3] = '{25, 5, 2, 0, 2,  5, 2, 0, 2};
    vecs[4] = '{39, 9, 3, 0, 3,  9, 3, 0, 3};
    vecs[5] = '{40, 0, 4, 0, 4,  9, 3, 1, 3};
    vecs[6] = '{45, 5, 4, 0, 4,  9, 3, 1, 3};

    rst_n_i = 1'b0; pulse_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; ack_i = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_lo", int'(lo_a), 0);
    rst_n_i = 1'b1;
    tick();

    // Reset mid-gate must drop everything at once, including an earlier latched result.
    strobe(1'b1, 1'b0, 1'b0);
    pulses(12, 1'b0);
    repeat (2) tick();
    strobe(1'b0, 1'b1, 1'b0);
    chk("pre_rst_lo", int'(lo_a), 2);
    chk("pre_rst_hi", int'(hi_a), 1);
    strobe(1'b1, 1'b0, 1'b1);
    pulses(3, 1'b0);
    chk("pre_rst_busy", int'(busy_a), 1);
    #3 rst_n_i = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy_a), 0);
    chk("async_rst_lo", int'(lo_a), 0);
    chk("async_rst_hi", int'(hi_a), 0);
    chk("async_rst_valid", int'(valid_a), 0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // start and stop together: no effect in IDLE, closes the gate in COUNT.
    strobe(1'b1, 1'b1, 1'b0);
    chk("ss_idle_busy", int'(busy_a), 0);
    chk("ss_idle_valid", int'(valid_a), 0);
    strobe(1'b1, 1'b0, 1'b0);
    chk("open_busy", int'(busy_a), 1);
    pulses(3, 1'b0);
    repeat (2) tick();
    strobe(1'b1, 1'b1, 1'b0);
    chk("ss_count_busy", int'(busy_a), 0);
    chk("ss_count_valid", int'(valid_a), 1);
    chk("ss_count_lo", int'(lo_a), 3);

    // Handshake: start without ack ignored; ack with start reopens with cleared counters.
    strobe(1'b1, 1'b0, 1'b0);
    chk("hold_start_busy", int'(busy_a), 0);
    chk("hold_start_valid", int'(valid_a), 1);
    chk("hold_start_lo", int'(lo_a), 3);
    strobe(1'b1, 1'b0, 1'b1);
    chk("ackstart_valid", int'(valid_a), 0);
    chk("ackstart_busy", int'(busy_a), 1);
    strobe(1'b0, 1'b1, 1'b0);
    chk("cleared_lo", int'(lo_a), 0);
    chk("cleared_hi", int'(hi_a), 0);

    foreach (vecs[i]) begin
      strobe(1'b0, 1'b0, 1'b1);
      strobe(1'b1, 1'b0, 1'b0);
      gate_and_check($sformatf("vec%0d", i), vecs[i].n, 1'b0,
                     vecs[i].lo_a, vecs[i].hi_a, vecs[i].ovf_a, vecs[i].wr_a,
                     vecs[i].lo_b, vecs[i].hi_b, vecs[i].ovf_b, vecs[i].wr_b);
    end

    // Timed gate: pulse every 4 clocks, gate closes itself after GATE_C cycles.
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    begin
      int b0, tot;
      b0 = busy_cnt_c;
      strobe(1'b1, 1'b0, 1'b0);
      pulses(27, 1'b0);
      repeat (3) tick();
      chk("timed_busy_cycles", busy_cnt_c - b0, GATE_C);
      chk("timed_valid", int'(valid_c), 1);
      chk("timed_busy_low", int'(busy_c), 0);
      tot = int'(lo_c) + M * int'(hi_c);
      chk("timed_total_in_24_26", int'(tot >= 24 && tot <= 26), 1);
      strobe(1'b0, 1'b1, 1'b0);
    end

    for (int it = 0; it < 25; it++) begin
      int n, la, ha, oa, wa, lb, hb, ob, wb;
      n = int'($urandom_range(0, 180));
      model(n, HIW_A, la, ha, oa, wa);
      model(n, HIW_B, lb, hb, ob, wb);
      if ($urandom_range(0, 1) == 1) begin
        strobe(1'b1, 1'b0, 1'b1);
      end else begin
        strobe(1'b0, 1'b0, 1'b1);
        strobe(1'b1, 1'b0, 1'b0);
      end
      gate_and_check($sformatf("rnd%0d_n%0d", it, n), n, 1'b1, la, ha, oa, wa, lb, hb, ob, wb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
